load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Sits between the core's execute/memory stage and Data_Memory (word-only RAM, comb read, posedge write).
//  Adds byte/halfword loads and stores (RV32I LB/LH/LW/LBU/LHU, SB/SH/SW) via read-modify-write.
//  Adds alignment and range checking, and a registered load result.
//  Sub-word stores take 2 cycles; the core stalls on req_ready_o.
// PARAMETERS
//  DATA_WIDTH    32            data/address width (only 32 supported)
//  BASE_ADDR     32'h10010000  byte address of RAM word 0
//  MEMORY_DEPTH  256           RAM depth in words; valid range is BASE_ADDR .. BASE_ADDR+4*MEMORY_DEPTH-1
// PORTS
//  clk           in   1   clock, all state on rising edge
//  reset         in   1   asynchronous, active-low reset
//  req_valid_i   in   1   access request this cycle
//  req_write_i   in   1   1 = store, 0 = load
//  req_funct3_i  in   3   RV32I funct3 (size/sign)
//  req_addr_i    in   32  byte address
//  req_wdata_i   in   32  store data (size-aligned in LSBs)
//  req_ready_o   out  1   request accepted when valid & ready at clock edge
//  load_data_o   out  32  extended load result (registered)
//  load_valid_o  out  1   one-cycle pulse: load_data_o updated
//  access_err_o  out  1   one-cycle pulse: request rejected
//  Mem_Write_o   out  1   to Data_Memory Mem_Write_i
//  Mem_Read_o    out  1   to Data_Memory Mem_Read_i
//  Address_o     out  32  to Data_Memory Address_i; word-aligned (bits[1:0]=0)
//  Write_Data_o  out  32  to Data_Memory Write_Data_i
//  Read_Data_i   in   32  from Data_Memory Read_Data_o (combinational)
// BEHAVIOUR
//  Reset: state=IDLE; load_data_o=0; load_valid_o=0; access_err_o=0; internal addr/merge regs=0.
//   Mem_Write_o and Mem_Read_o are forced 0 while reset is low; no request is accepted during reset.
//  FSM states: IDLE, RMW_WR. req_ready_o = (state==IDLE).
//  Request legality:
//   - Legal funct3, load:  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
//   - Legal funct3, store: 000 SB, 001 SH, 010 SW.
//   - Any other funct3 is illegal.
//   - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
//   - Out of range: addr<BASE_ADDR or addr>=BASE_ADDR+4*MEMORY_DEPTH (32-bit unsigned compare).
//   - Illegal, misaligned or out-of-range: no Mem_Read/Mem_Write; access_err_o=1 next cycle; load_valid_o=0; stay IDLE.
//  Load accepted in IDLE:
//   - Same cycle: Mem_Read_o=1, Address_o={addr[31:2],2'b00}.
//   - At the edge, select byte addr[1:0] or half addr[1], then zero- or sign-extend into load_data_o.
//   - load_valid_o=1 next cycle. Latency 1; back-to-back loads every cycle.
//  SW accepted in IDLE: same cycle Mem_Write_o=1, Write_Data_o=req_wdata_i; stay IDLE; single cycle.
//  SB/SH accepted in IDLE:
//   - Cycle 0: Mem_Read_o=1; register Read_Data_i with the addressed lane(s) replaced by wdata[7:0]/[15:0],
//     plus the aligned address; go to RMW_WR.
//   - Cycle 1 (RMW_WR): Mem_Write_o=1, Address_o=latched addr, Write_Data_o=merged word, req_ready_o=0; go to IDLE.
//  Defaults when not driven: Mem_Write_o=0, Mem_Read_o=0, Write_Data_o=0.
//   Address_o carries the request address when IDLE and the latched address in RMW_WR.
//  load_data_o holds its value until the next successful load. Stores never pulse load_valid_o.
//  req_valid_i during RMW_WR is ignored; the core must hold the request until ready.
//  Reset low in RMW_WR: write is aborted (Mem_Write_o=0 immediately) and the memory word is unchanged.
// TESTING
//  1 SW 0x10010004 data 0xDEADBEEF -> Mem_Write_o=1 same cycle, Address_o=0x10010004;
//    then LW same addr -> load_data_o=0xDEADBEEF, load_valid_o=1 one cycle later.
//  2 SB 0x10010005 data 0x000000AA -> req_ready_o=0 one cycle, memory word=0xDEADAAEF;
//    then LBU -> 0x000000AA; LB -> 0xFFFFFFAA.
//  3 SH 0x10010006 data 0x00001234 -> word=0x1234AAEF;
//    then LH -> 0x00001234; LHU 0x10010004 -> 0x0000AAEF; LH 0x10010004 -> 0xFFFFAAEF.
//  4 Rejects -> access_err_o pulse, no Mem_Read_o/Mem_Write_o, load_data_o unchanged:
//    LW 0x10010002 (misaligned); SH 0x10010001 (misaligned); LW 0x10010400 (out of range); funct3=011 (illegal).
//  5 Issue SB, assert reset low during RMW_WR -> Mem_Write_o=0, word unchanged on readback;
//    after release all outputs 0 and req_ready_o=1.
//  6 Four back-to-back LWs then SB with req_valid_i held -> load_valid_o high 4 consecutive cycles with correct data;
//    SB accepted once, write occurs exactly once.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the core memory stage and a word-only Data_Memory.
// Adds sub-word loads/stores (read-modify-write), alignment/range checks and a registered load result.
module load_store_unit #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h10010000,
    parameter int unsigned MEMORY_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  req_ready_o,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output logic                  load_valid_o,
    output logic                  access_err_o,
    output logic                  Mem_Write_o,
    output logic                  Mem_Read_o,
    output logic [DATA_WIDTH-1:0] Address_o,
    output logic [DATA_WIDTH-1:0] Write_Data_o,
    input  logic [DATA_WIDTH-1:0] Read_Data_i
);

    localparam logic [31:0] LIMIT_ADDR = BASE_ADDR + 32'(4 * MEMORY_DEPTH);

    typedef enum logic {
        IDLE,
        RMW_WR
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] merge_q;

    logic                  funct3_ok;
    logic                  aligned;
    logic                  in_range;
    logic                  legal;
    logic                  accept;
    logic                  req_ok;
    logic                  req_bad;
    logic                  is_word;
    logic                  sub_store;
    logic [DATA_WIDTH-1:0] word_addr;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;

    always_comb begin
        funct3_ok = 1'b0;
        case (req_funct3_i)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = ~req_write_i;
            default:                funct3_ok = 1'b0;
        endcase
    end

    always_comb begin
        aligned = 1'b1;
        case (req_funct3_i[1:0])
            2'b01:   aligned = ~req_addr_i[0];
            2'b10:   aligned = (req_addr_i[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign in_range  = (req_addr_i >= BASE_ADDR) && (req_addr_i < LIMIT_ADDR);
    assign legal     = funct3_ok & aligned & in_range;
    assign accept    = req_valid_i & (state == IDLE);
    assign req_ok    = accept & legal;
    assign req_bad   = accept & ~legal;
    assign is_word   = (req_funct3_i[1:0] == 2'b10);
    assign sub_store = req_ok & req_write_i & ~is_word;
    assign word_addr = {req_addr_i[DATA_WIDTH-1:2], 2'b00};

    assign req_ready_o = (state == IDLE);

    // Memory strobes are gated by reset so an in-flight RMW write is dropped immediately.
    assign Mem_Read_o  = reset & req_ok & (~req_write_i | ~is_word);
    assign Mem_Write_o = reset & ((state == RMW_WR) | (req_ok & req_write_i & is_word));
    assign Address_o   = (state == RMW_WR) ? addr_q : word_addr;

    always_comb begin
        Write_Data_o = '0;
        if (state == RMW_WR)
            Write_Data_o = merge_q;
        else if (req_ok & req_write_i & is_word)
            Write_Data_o = req_wdata_i;
    end

    always_comb begin
        sel_byte = Read_Data_i[7:0];
        case (req_addr_i[1:0])
            2'd0: sel_byte = Read_Data_i[7:0];
            2'd1: sel_byte = Read_Data_i[15:8];
            2'd2: sel_byte = Read_Data_i[23:16];
            2'd3: sel_byte = Read_Data_i[31:24];
            default: sel_byte = Read_Data_i[7:0];
        endcase
        sel_half = req_addr_i[1] ? Read_Data_i[31:16] : Read_Data_i[15:0];
    end

    always_comb begin
        load_ext = Read_Data_i;
        case (req_funct3_i)
            3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_ext = {24'h0, sel_byte};
            3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_ext = {16'h0, sel_half};
            default: load_ext = Read_Data_i;
        endcase
    end

    always_comb begin
        merged = Read_Data_i;
        if (req_funct3_i[1:0] == 2'b00) begin
            case (req_addr_i[1:0])
                2'd0: merged[7:0]   = req_wdata_i[7:0];
                2'd1: merged[15:8]  = req_wdata_i[7:0];
                2'd2: merged[23:16] = req_wdata_i[7:0];
                2'd3: merged[31:24] = req_wdata_i[7:0];
                default: merged = Read_Data_i;
            endcase
        end else if (req_addr_i[1]) begin
            merged[31:16] = req_wdata_i[15:0];
        end else begin
            merged[15:0] = req_wdata_i[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            load_data_o  <= '0;
            load_valid_o <= 1'b0;
            access_err_o <= 1'b0;
            addr_q       <= '0;
            merge_q      <= '0;
        end else begin
            load_valid_o <= req_ok & ~req_write_i;
            access_err_o <= req_bad;
            if (req_ok & ~req_write_i)
                load_data_o <= load_ext;
            case (state)
                IDLE: begin
                    if (sub_store) begin
                        addr_q  <= word_addr;
                        merge_q <= merged;
                        state   <= RMW_WR;
                    end
                end
                RMW_WR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
